fifo_wr_ptr_ctrl: RTL and testbench

//  Write-domain controller of the async FIFO; pointer-generating end of the dual-flop Gray-pointer sync path.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_wr_ptr_ctrl_gray2bin.sv | 11 +
 rtl/fifo_wr_ptr_ctrl.sv | 81 ++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and pointer helpers for the async FIFO pointer controllers.
package fifo_pkg;
  localparam int MEM_DEPTH_DFLT = 8;
  localparam int ADDR_W         = $clog2(MEM_DEPTH_DFLT);
  localparam int PTR_W          = ADDR_W + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/fifo_wr_ptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end
endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of the async FIFO: binary/Gray write pointer, full/almost-full,
// pessimistic fill level and sticky overflow, all against the synchronized read Gray pointer.
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int MEM_DEPTH = MEM_DEPTH_DFLT,
  parameter  int AF_THRESH = MEM_DEPTH - 2,
  localparam int C_ADDR_W  = $clog2(MEM_DEPTH),
  localparam int C_PTR_W   = C_ADDR_W + 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               W_INC,
  input  logic [C_PTR_W-1:0] WQ2_RPTR,
  input  logic               OVF_CLR,
  output logic [C_PTR_W-2:0] W_ADDR,
  output logic               W_CLKEN,
  output logic [C_PTR_W-1:0] W_GPTR,
  output logic               FULL,
  output logic               ALMOST_FULL,
  output logic [C_PTR_W-1:0] W_LEVEL,
  output logic               OVERFLOW
);
  logic [C_PTR_W-1:0] r_wbin;
  logic [C_PTR_W-1:0] r_gptr;
  logic               r_full;
  logic               r_afull;
  logic [C_PTR_W-1:0] r_level;
  logic               r_ovf;

  logic               w_accept;
  logic [C_PTR_W-1:0] w_wbin_nxt;
  logic [C_PTR_W-1:0] w_gnxt;
  logic [C_PTR_W-1:0] w_rbin;
  logic [C_PTR_W-1:0] w_level_nxt;
  logic [C_PTR_W-1:0] w_rptr_full;
  logic               w_full_nxt;

  gray2bin #(.WIDTH(C_PTR_W)) u_rptr_g2b (
    .i_gray (WQ2_RPTR),
    .o_bin  (w_rbin)
  );

  assign w_accept    = W_INC & ~r_full;
  assign w_wbin_nxt  = r_wbin + C_PTR_W'(w_accept);
  assign w_gnxt      = C_PTR_W'(bin2gray(32'(w_wbin_nxt)));
  assign w_level_nxt = w_wbin_nxt - w_rbin;

  // Full when the write pointer is one lap ahead: in Gray that flips the top two bits.
  assign w_rptr_full = {~WQ2_RPTR[C_PTR_W-1:C_PTR_W-2], WQ2_RPTR[C_PTR_W-3:0]};
  assign w_full_nxt  = (w_gnxt == w_rptr_full);

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_wbin  <= '0;
      r_gptr  <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_nxt;
      r_gptr  <= w_gnxt;
      r_full  <= w_full_nxt;
      r_afull <= (w_level_nxt >= C_PTR_W'(AF_THRESH));
      r_level <= w_level_nxt;
      if (W_INC && r_full)
        r_ovf <= 1'b1;
      else if (OVF_CLR)
        r_ovf <= 1'b0;
    end
  end

  assign W_ADDR      = r_wbin[C_PTR_W-2:0];
  assign W_CLKEN     = w_accept;
  assign W_GPTR      = r_gptr;
  assign FULL        = r_full;
  assign ALMOST_FULL = r_afull;
  assign W_LEVEL     = r_level;
  assign OVERFLOW    = r_ovf;
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl (MEM_DEPTH=8, AF_THRESH=6): table vectors plus model-driven sequences.
module tb_fifo_wr_ptr_ctrl;
  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       W_INC = 1'b0;
  logic [3:0] WQ2_RPTR = 4'b0000;
  logic       OVF_CLR = 1'b0;
  logic [2:0] W_ADDR;
  logic       W_CLKEN;
  logic [3:0] W_GPTR;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [3:0] W_LEVEL;
  logic       OVERFLOW;

  fifo_wr_ptr_ctrl #(.MEM_DEPTH(8), .AF_THRESH(6)) dut (
    .clk         (clk),
    .RST         (RST),
    .W_INC       (W_INC),
    .WQ2_RPTR    (WQ2_RPTR),
    .OVF_CLR     (OVF_CLR),
    .W_ADDR      (W_ADDR),
    .W_CLKEN     (W_CLKEN),
    .W_GPTR      (W_GPTR),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .W_LEVEL     (W_LEVEL),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       w_inc;
    logic       ovf_clr;
    logic [3:0] rptr;
    logic       chk_pre;
    logic       clken;
    logic [2:0] addr;
    logic [3:0] gptr;
    logic       full;
    logic       af;
    logic [3:0] level;
    logic       ovf;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[19];
  vec_t e_chk;
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_step  = 0;

  logic [3:0] m_wbin, m_gptr, m_level;
  logic       m_full, m_af, m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d: got %0h want %0h", nm, n_step, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst_n, w_inc, ovf_clr, input logic [3:0] rptr,
                              input logic chk_pre, clken, input logic [2:0] addr,
                              input logic [3:0] gptr, input logic full, af,
                              input logic [3:0] level, input logic ovf);
    vec_t v;
    v.rst_n = rst_n; v.w_inc = w_inc; v.ovf_clr = ovf_clr; v.rptr = rptr;
    v.chk_pre = chk_pre; v.clken = clken; v.addr = addr; v.gptr = gptr;
    v.full = full; v.af = af; v.level = level; v.ovf = ovf;
    return v;
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle: combinational outputs checked before the edge, registered ones queued.
  task automatic apply(input vec_t v);
    @(negedge clk);
    RST = v.rst_n; W_INC = v.w_inc; OVF_CLR = v.ovf_clr; WQ2_RPTR = v.rptr;
    n_step++;
    #1;
    if (v.chk_pre) begin
      chk("w_clken", W_CLKEN, v.clken);
      chk("w_addr", W_ADDR, v.addr);
    end
    exp_q.push_back(v);
  endtask

  // Reference behaviour of the write controller, advanced one edge per call.
  task automatic mstep(input logic rst_n, w_inc, ovf_clr, input logic [3:0] rptr);
    logic [3:0] nxt;
    logic       acc;
    vec_t       v;
    v = mk(rst_n, w_inc, ovf_clr, rptr, 1'b1, w_inc & ~m_full, m_wbin[2:0],
           4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    if (!rst_n) begin
      m_wbin = 0; m_gptr = 0; m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
    end else begin
      acc = w_inc & ~m_full;
      nxt = m_wbin + {3'b000, acc};
      if (w_inc && m_full) m_ovf = 1'b1;
      else if (ovf_clr)    m_ovf = 1'b0;
      m_gptr  = nxt ^ (nxt >> 1);
      m_level = nxt - g2b(rptr);
      m_af    = (m_level >= 4'd6);
      m_full  = (m_gptr == {~rptr[3:2], rptr[1:0]});
      m_wbin  = nxt;
    end
    v.gptr = m_gptr; v.full = m_full; v.af = m_af; v.level = m_level; v.ovf = m_ovf;
    apply(v);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_chk = exp_q.pop_front();
      chk("w_gptr", W_GPTR, e_chk.gptr);
      chk("full", FULL, e_chk.full);
      chk("almost_full", ALMOST_FULL, e_chk.af);
      chk("w_level", W_LEVEL, e_chk.level);
      chk("overflow", OVERFLOW, e_chk.ovf);
    end
  end

  initial begin
    logic [3:0] gh1, gh2, prev_g;

    //            rst inc clr rptr   pre clk addr  gptr    full af level  ovf
    tbl[0]  = mk(0, 0, 0, 4'b0000, 0, 0, 3'd0, 4'b0000, 0, 0, 4'd0, 0);
    tbl[1]  = mk(0, 0, 0, 4'b0000, 1, 0, 3'd0, 4'b0000, 0, 0, 4'd0, 0);
    tbl[2]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd0, 4'b0001, 0, 0, 4'd1, 0);
    tbl[3]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd1, 4'b0011, 0, 0, 4'd2, 0);
    tbl[4]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd2, 4'b0010, 0, 0, 4'd3, 0);
    tbl[5]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd3, 4'b0110, 0, 0, 4'd4, 0);
    tbl[6]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd4, 4'b0111, 0, 0, 4'd5, 0);
    tbl[7]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd5, 4'b0101, 0, 1, 4'd6, 0);
    tbl[8]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd6, 4'b0100, 0, 1, 4'd7, 0);
    tbl[9]  = mk(1, 1, 0, 4'b0000, 1, 1, 3'd7, 4'b1100, 1, 1, 4'd8, 0);
    tbl[10] = mk(1, 1, 0, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
    tbl[11] = mk(1, 1, 0, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
    tbl[12] = mk(1, 1, 0, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
    tbl[13] = mk(1, 0, 0, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
    tbl[14] = mk(1, 0, 1, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 0);
    tbl[15] = mk(1, 1, 1, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
    tbl[16] = mk(1, 0, 1, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 0);
    tbl[17] = mk(1, 0, 0, 4'b0001, 1, 0, 3'd0, 4'b1100, 0, 1, 4'd7, 0);
    tbl[18] = mk(1, 1, 0, 4'b0001, 1, 1, 3'd0, 4'b1101, 1, 1, 4'd8, 0);

    // Arbitrary activity so the reset rows start from a non-trivial state.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      W_INC = 1'($urandom); OVF_CLR = 1'($urandom); WQ2_RPTR = 4'($urandom);
    end

    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // Reset driven low between edges must not act until the next edge.
    @(negedge clk);
    RST = 1'b0; W_INC = 1'b0; OVF_CLR = 1'b0;
    #2;
    chk("rst_hold_gptr", W_GPTR, 4'b1101);
    chk("rst_hold_full", FULL, 1'b1);
    chk("rst_hold_level", W_LEVEL, 4'd8);
    @(posedge clk); #2;
    chk("rst_edge_gptr", W_GPTR, 4'b0000);
    chk("rst_edge_full", FULL, 1'b0);
    chk("rst_edge_level", W_LEVEL, 4'd0);
    m_wbin = 0; m_gptr = 0; m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
    mstep(0, 0, 0, 4'b0000);

    // Reader trails two cycles behind; 20 writes cross the pointer wrap.
    gh1 = 4'b0000; gh2 = 4'b0000; prev_g = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      mstep(1, 1, 0, gh2);
      gh2 = gh1; gh1 = m_gptr;
      @(posedge clk); #2;
      chk("gray_one_bit", $countones(W_GPTR ^ prev_g), 1);
      chk("level_le2", (W_LEVEL <= 4'd2), 1'b1);
      prev_g = W_GPTR;
    end

    // Reset in the middle of a burst at wbin=5.
    mstep(0, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) mstep(1, 1, 0, 4'b0000);
    mstep(0, 1, 0, 4'b0000);
    mstep(1, 1, 0, 4'b0000);
    mstep(1, 0, 0, 4'b0000);

    @(posedge clk); #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
